// File: rtl/n64_vbus_demux_if.sv
// n64_vbus_demux_if: N64 video bus in, demuxed sync/pixel stream out
interface n64_vbus_demux_if;
  logic        nVDSYNC;
  logic [6:0]  D_i;
  logic        nVDSYNC_o;
  logic [3:0]  Sync_pre;
  logic [3:0]  Sync_cur;
  logic [24:0] vdata_o;
  logic        vdata_valid_o;
  logic [7:0]  phase_err_cnt_o;
  modport master (
    output nVDSYNC, D_i,
    input  nVDSYNC_o, Sync_pre, Sync_cur, vdata_o, vdata_valid_o, phase_err_cnt_o
  );
  modport slave (
    input  nVDSYNC, D_i,
    output nVDSYNC_o, Sync_pre, Sync_cur, vdata_o, vdata_valid_o, phase_err_cnt_o
  );
endinterface

// File: rtl/n64_vbus_demux.sv
// n64_vbus_demux: splits the 4-phase N64 video bus into sync words and {sync,R,G,B} pixels.
// Define VBUS_PHASE_ERRCNT_EN to build the saturating bus-phase error counter.
module n64_vbus_demux (
  input  logic VCLK,
  input  logic nRST,
  n64_vbus_demux_if.slave bus
);
  typedef enum logic [2:0] {WAIT, SYNC, RED, GRN, BLU} state_t;
  state_t     state, state_nxt;
  logic       nvdsync_r;
  logic [6:0] d_r, r_q, g_q;
  logic       ld_sync, ld_r, ld_g, ld_pix;
  assign ld_sync = !nvdsync_r;
  assign ld_r    = nvdsync_r && state == SYNC;
  assign ld_g    = nvdsync_r && state == RED;
  assign ld_pix  = nvdsync_r && state == GRN;
  always_ff @(posedge VCLK or negedge nRST)
    if (!nRST) state <= WAIT;
    else       state <= state_nxt;
  // a sync phase always restarts the pixel; a missing sync after BLU parks in WAIT
  always_comb begin
    state_nxt = WAIT;
    if (!nvdsync_r) state_nxt = SYNC;
    else
      case (state)
        SYNC:    state_nxt = RED;
        RED:     state_nxt = GRN;
        GRN:     state_nxt = BLU;
        default: state_nxt = WAIT;
      endcase
  end
  always_ff @(posedge VCLK or negedge nRST)
    if (!nRST) begin
      nvdsync_r         <= 1'b1;
      d_r               <= '0;
      r_q               <= '0;
      g_q               <= '0;
      bus.nVDSYNC_o     <= 1'b1;
      bus.Sync_pre      <= 4'hF;
      bus.Sync_cur      <= 4'hF;
      bus.vdata_o       <= '0;
      bus.vdata_valid_o <= 1'b0;
    end else begin
      nvdsync_r         <= bus.nVDSYNC;
      d_r               <= bus.D_i;
      bus.nVDSYNC_o     <= nvdsync_r;
      bus.vdata_valid_o <= ld_pix;
      if (ld_sync) begin
        bus.Sync_pre <= bus.Sync_cur;
        bus.Sync_cur <= d_r[3:0];
      end
      if (ld_r)   r_q         <= d_r;
      if (ld_g)   g_q         <= d_r;
      if (ld_pix) bus.vdata_o <= {bus.Sync_cur, r_q, g_q, d_r};
    end
`ifdef VBUS_PHASE_ERRCNT_EN
  logic err;
  assign err = nvdsync_r ? state == BLU : state inside {SYNC, RED, GRN};
  always_ff @(posedge VCLK or negedge nRST)
    if (!nRST) bus.phase_err_cnt_o <= '0;
    else if (err && bus.phase_err_cnt_o != 8'hFF) bus.phase_err_cnt_o <= bus.phase_err_cnt_o + 8'd1;
`else
  assign bus.phase_err_cnt_o = 8'h00;
`endif
endmodule

// File: tb/tb_n64_vbus_demux.sv
// tb_n64_vbus_demux: directed vectors for the N64 video bus demux
module tb_n64_vbus_demux;
  logic VCLK = 1'b0;
  logic nRST = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_strobe = 0;
  logic [24:0] prev;
  n64_vbus_demux_if bus ();
  n64_vbus_demux dut (.VCLK(VCLK), .nRST(nRST), .bus(bus));
  always #5 VCLK = ~VCLK;
`ifdef VBUS_PHASE_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic nv, input logic [6:0] d);
    bus.nVDSYNC = nv;
    bus.D_i     = d;
    @(posedge VCLK);
    #1;
  endtask
  function automatic logic [24:0] px(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g, input logic [6:0] b);
    return {s, r, g, b};
  endfunction
  function automatic logic [7:0] ecnt(input int n);
    return CNT_EN ? (n > 255 ? 8'hFF : 8'(n)) : 8'h00;
  endfunction
  task automatic chk_reset(input string tag);
    check({tag, "_pre"},   bus.Sync_pre, 4'hF);
    check({tag, "_cur"},   bus.Sync_cur, 4'hF);
    check({tag, "_nvo"},   bus.nVDSYNC_o, 1'b1);
    check({tag, "_vdata"}, bus.vdata_o, 25'h0);
    check({tag, "_valid"}, bus.vdata_valid_o, 1'b0);
    check({tag, "_cnt"},   bus.phase_err_cnt_o, 8'h00);
  endtask
  initial begin
    bus.nVDSYNC = 1'b1;
    bus.D_i     = '0;
    drive(1'b1, 7'h00);
    drive(1'b1, 7'h00);
    chk_reset("rst");
    nRST = 1'b1;
    drive(1'b0, 7'h0F);
    drive(1'b1, 7'h11);
    check("s0_cur", bus.Sync_cur, 4'hF);
    check("s0_nvo", bus.nVDSYNC_o, 1'b0);
    drive(1'b1, 7'h22);
    check("r0_nvo", bus.nVDSYNC_o, 1'b1);
    drive(1'b1, 7'h33);
    check("g0_valid", bus.vdata_valid_o, 1'b0);
    drive(1'b0, 7'h07);
    check("p0_valid", bus.vdata_valid_o, 1'b1);
    check("p0_vdata", bus.vdata_o, px(4'hF, 7'h11, 7'h22, 7'h33));
    drive(1'b1, 7'h44);
    check("s1_pre", bus.Sync_pre, 4'hF);
    check("s1_cur", bus.Sync_cur, 4'h7);
    check("s1_nvo", bus.nVDSYNC_o, 1'b0);
    check("s1_valid", bus.vdata_valid_o, 1'b0);
    drive(1'b1, 7'h55);
    check("r1_nvo", bus.nVDSYNC_o, 1'b1);
    check("r1_cur", bus.Sync_cur, 4'h7);
    drive(1'b1, 7'h66);
    prev = px(4'h7, 7'h44, 7'h55, 7'h66);
    for (int i = 0; i < 100; i++) begin
      logic [6:0] v;
      v = 7'(i);
      drive(1'b0, {3'b000, v[3:0]});
      if (bus.vdata_valid_o) n_strobe++;
      check("loop_valid_b", bus.vdata_valid_o, 1'b1);
      check("loop_vdata", bus.vdata_o, prev);
      drive(1'b1, v);
      if (bus.vdata_valid_o) n_strobe++;
      check("loop_valid_s", bus.vdata_valid_o, 1'b0);
      drive(1'b1, ~v);
      if (bus.vdata_valid_o) n_strobe++;
      check("loop_valid_r", bus.vdata_valid_o, 1'b0);
      drive(1'b1, v ^ 7'h55);
      if (bus.vdata_valid_o) n_strobe++;
      check("loop_valid_g", bus.vdata_valid_o, 1'b0);
      prev = px(v[3:0], v, ~v, v ^ 7'h55);
    end
    check("loop_strobes", n_strobe, 100);
    check("loop_cnt", bus.phase_err_cnt_o, 8'h00);
    drive(1'b0, 7'h0A);
    check("p99_vdata", bus.vdata_o, prev);
    drive(1'b1, 7'h12);
    drive(1'b0, 7'h0B);
    drive(1'b1, 7'h21);
    check("perr_valid", bus.vdata_valid_o, 1'b0);
    check("perr_pre", bus.Sync_pre, 4'hA);
    check("perr_cur", bus.Sync_cur, 4'hB);
    check("perr_cnt", bus.phase_err_cnt_o, ecnt(1));
    drive(1'b1, 7'h22);
    check("perr_valid_r", bus.vdata_valid_o, 1'b0);
    drive(1'b1, 7'h23);
    check("perr_valid_g", bus.vdata_valid_o, 1'b0);
    drive(1'b0, 7'h0C);
    check("perr_pix_valid", bus.vdata_valid_o, 1'b1);
    check("perr_pix", bus.vdata_o, px(4'hB, 7'h21, 7'h22, 7'h23));
    drive(1'b1, 7'h31);
    drive(1'b1, 7'h32);
    drive(1'b1, 7'h33);
    drive(1'b1, 7'h40);
    check("wait_pix_valid", bus.vdata_valid_o, 1'b1);
    check("wait_pix", bus.vdata_o, px(4'hC, 7'h31, 7'h32, 7'h33));
    drive(1'b1, 7'h41);
    check("wait_valid0", bus.vdata_valid_o, 1'b0);
    check("wait_cnt", bus.phase_err_cnt_o, ecnt(2));
    drive(1'b1, 7'h42);
    check("wait_valid1", bus.vdata_valid_o, 1'b0);
    drive(1'b0, 7'h0D);
    check("wait_valid2", bus.vdata_valid_o, 1'b0);
    check("wait_hold", bus.vdata_o, px(4'hC, 7'h31, 7'h32, 7'h33));
    check("wait_cur", bus.Sync_cur, 4'hC);
    drive(1'b1, 7'h51);
    check("resume_pre", bus.Sync_pre, 4'hC);
    check("resume_cur", bus.Sync_cur, 4'hD);
    check("resume_nvo", bus.nVDSYNC_o, 1'b0);
    drive(1'b1, 7'h52);
    drive(1'b1, 7'h53);
    drive(1'b0, 7'h0E);
    check("resume_valid", bus.vdata_valid_o, 1'b1);
    check("resume_pix", bus.vdata_o, px(4'hD, 7'h51, 7'h52, 7'h53));
    check("resume_cnt", bus.phase_err_cnt_o, ecnt(2));
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 7'h0F);
      if (i == 100) check("sat_mid", bus.phase_err_cnt_o, ecnt(102));
    end
    check("sat_end", bus.phase_err_cnt_o, ecnt(301));
    drive(1'b1, 7'h61);
    drive(1'b1, 7'h62);
    drive(1'b1, 7'h63);
    #2;
    nRST = 1'b0;
    #1;
    chk_reset("arst");
    drive(1'b1, 7'h00);
    drive(1'b1, 7'h00);
    nRST = 1'b1;
    drive(1'b1, 7'h70);
    check("post_valid", bus.vdata_valid_o, 1'b0);
    check("post_vdata", bus.vdata_o, 25'h0);
    drive(1'b0, 7'h09);
    drive(1'b1, 7'h01);
    check("post_pre", bus.Sync_pre, 4'hF);
    check("post_cur", bus.Sync_cur, 4'h9);
    drive(1'b1, 7'h02);
    drive(1'b1, 7'h03);
    drive(1'b0, 7'h09);
    check("post_pix_valid", bus.vdata_valid_o, 1'b1);
    check("post_pix", bus.vdata_o, px(4'h9, 7'h01, 7'h02, 7'h03));
    check("post_cnt", bus.phase_err_cnt_o, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
